ex_stage_mc: RTL

EX_STAGE_MC -- requirements
Module: ex_stage_mc

---
 rtl/ex_stage_mc.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage_mc.sv
// Execute stage with operand forwarding, ALU, branch resolution, an iterative
// shift-add multiplier and the EX/M pipeline register.
module ex_stage_mc #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_e,
  input  logic            stall_m,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [REGW-1:0] rd_e,
  input  logic [1:0]      fwd_a_e,
  input  logic [1:0]      fwd_b_e,
  input  logic [XLEN-1:0] result_w,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic            jalr_e,
  input  logic            alu_src_e,
  input  logic            mul_e,
  input  logic [1:0]      result_src_e,
  input  logic [2:0]      funct3_e,
  input  logic [3:0]      alu_control_e,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [REGW-1:0] rd_m,
  output logic [XLEN-1:0] pc_target_e,
  output logic            pc_src_e,
  output logic            busy_e
);

  localparam int SHW  = $clog2(XLEN);
  localparam int CNTW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mulState_t;

  mulState_t       mulState;
  logic [CNTW-1:0] mulCnt;
  logic [XLEN-1:0] mulA;
  logic [XLEN-1:0] mulB;
  logic [XLEN-1:0] mulAcc;

  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcBReg;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] aluOut;
  logic [XLEN-1:0] exResult;
  logic [SHW-1:0]  shamt;
  logic            branchCond;
  logic            mulStart;

  always_comb begin
    srcA = rd1_e;
    case (fwd_a_e)
      2'b01:   srcA = result_w;
      2'b10:   srcA = alu_result_m;
      default: srcA = rd1_e;
    endcase
  end

  always_comb begin
    srcBReg = rd2_e;
    case (fwd_b_e)
      2'b01:   srcBReg = result_w;
      2'b10:   srcBReg = alu_result_m;
      default: srcBReg = rd2_e;
    endcase
  end

  assign srcB  = alu_src_e ? imm_e : srcBReg;
  assign shamt = srcB[SHW-1:0];

  always_comb begin
    aluOut = '0;
    case (alu_control_e)
      4'd0:    aluOut = srcA + srcB;
      4'd1:    aluOut = srcA - srcB;
      4'd2:    aluOut = srcA & srcB;
      4'd3:    aluOut = srcA | srcB;
      4'd4:    aluOut = srcA ^ srcB;
      4'd5:    aluOut = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      4'd6:    aluOut = {{(XLEN-1){1'b0}}, (srcA < srcB)};
      4'd7:    aluOut = srcA << shamt;
      4'd8:    aluOut = srcA >> shamt;
      4'd9:    aluOut = XLEN'($signed(srcA) >>> shamt);
      default: aluOut = '0;
    endcase
  end

  // Branches compare against the forwarded register operand, never the immediate.
  always_comb begin
    branchCond = 1'b0;
    case (funct3_e)
      3'b000:  branchCond = (srcA == srcBReg);
      3'b001:  branchCond = (srcA != srcBReg);
      3'b100:  branchCond = ($signed(srcA) < $signed(srcBReg));
      3'b101:  branchCond = ($signed(srcA) >= $signed(srcBReg));
      3'b110:  branchCond = (srcA < srcBReg);
      3'b111:  branchCond = (srcA >= srcBReg);
      default: branchCond = 1'b0;
    endcase
  end

  always_comb begin
    pc_target_e = pc_e + imm_e;
    if (jalr_e) begin
      pc_target_e = srcA + imm_e;
      pc_target_e[0] = 1'b0;
    end
  end

  assign pc_src_e = ((branch_e & branchCond) | jump_e) & ~flush_e;

  // Gating with rst keeps busy_e low throughout reset even while mul_e is held.
  assign mulStart = (mulState == IDLE) & mul_e & ~flush_e;
  assign busy_e   = rst & (mulStart | (mulState == BUSY));
  assign exResult = (mulState == DONE) ? mulAcc : aluOut;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mulState <= IDLE;
      mulCnt   <= '0;
      mulA     <= '0;
      mulB     <= '0;
      mulAcc   <= '0;
    end else begin
      case (mulState)
        IDLE: begin
          if (mulStart) begin
            mulA     <= srcA;
            mulB     <= srcB;
            mulAcc   <= '0;
            mulCnt   <= CNTW'(XLEN);
            mulState <= BUSY;
          end
        end
        BUSY: begin
          if (flush_e) begin
            mulState <= IDLE;
            mulAcc   <= '0;
            mulCnt   <= '0;
          end else begin
            if (mulB[0]) begin
              mulAcc <= mulAcc + mulA;
            end
            mulA   <= mulA << 1;
            mulB   <= mulB >> 1;
            mulCnt <= mulCnt - 1'b1;
            if (mulCnt == CNTW'(1)) begin
              mulState <= DONE;
            end
          end
        end
        DONE: begin
          if (flush_e) begin
            mulState <= IDLE;
            mulAcc   <= '0;
          end else if (!stall_m) begin
            mulState <= IDLE;
          end
        end
        default: mulState <= IDLE;
      endcase
    end
  end

  // A stalled M stage holds everything, including across a flush of EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
    end else if (!stall_m) begin
      if (flush_e || busy_e) begin
        reg_write_m  <= 1'b0;
        mem_write_m  <= 1'b0;
        result_src_m <= '0;
        alu_result_m <= '0;
        write_data_m <= '0;
        pc_plus4_m   <= '0;
        rd_m         <= '0;
      end else begin
        reg_write_m  <= reg_write_e;
        mem_write_m  <= mem_write_e;
        result_src_m <= result_src_e;
        alu_result_m <= exResult;
        write_data_m <= srcBReg;
        pc_plus4_m   <= pc_plus4_e;
        rd_m         <= rd_e;
      end
    end
  end

endmodule
